// File: rtl/alu_result_pkg.sv
// rtl/alu_result_pkg.sv - shared constants and types for the ALU result stage
package alu_result_pkg;

    localparam int DATA_W = 16;
    localparam int REG_W  = 3;

    localparam logic [2:0] COND_AL = 3'b000;
    localparam logic [2:0] COND_EQ = 3'b001;
    localparam logic [2:0] COND_NE = 3'b010;
    localparam logic [2:0] COND_LT = 3'b011;
    localparam logic [2:0] COND_LE = 3'b100;

    localparam int ST_Z = 0;
    localparam int ST_N = 1;
    localparam int ST_V = 2;

    typedef struct packed {
        logic [DATA_W-1:0] c;
        logic [REG_W-1:0]  rd;
        logic              wb_en;
    } entry_t;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_e;

endpackage

// File: rtl/alu_result_stage_if.sv
// rtl/alu_result_stage_if.sv - ALU-side, writeback-side and branch signals of the result stage
interface alu_result_stage_if #(
    parameter int W  = 16,
    parameter int RW = 3
);
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  alu_out;
    logic          alu_z;
    logic          alu_n;
    logic          alu_ovf;
    logic          load_status;
    logic [RW-1:0] rd_in;
    logic          wb_en_in;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  C;
    logic [RW-1:0] rd_out;
    logic          wb_en_out;
    logic [2:0]    status;
    logic [2:0]    cond;
    logic          br_taken;

    modport slave (
        input  in_valid, alu_out, alu_z, alu_n, alu_ovf, load_status, rd_in, wb_en_in,
        input  out_ready, cond,
        output in_ready, out_valid, C, rd_out, wb_en_out, status, br_taken
    );

    modport master (
        output in_valid, alu_out, alu_z, alu_n, alu_ovf, load_status, rd_in, wb_en_in,
        output out_ready, cond,
        input  in_ready, out_valid, C, rd_out, wb_en_out, status, br_taken
    );
endinterface

// File: rtl/result_skid_buf.sv
// rtl/result_skid_buf.sv - generic two-entry valid/ready elastic buffer
module result_skid_buf
    import alu_result_pkg::*;
#(
    parameter int DW = 20
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [DW-1:0] in_data_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [DW-1:0] out_data_o
);

    buf_state_e    state_q, state_d;
    logic [DW-1:0] head_q, head_d;
    logic [DW-1:0] tail_q, tail_d;
    logic          in_ready_q, in_ready_d;
    logic          push, pop;

    assign push        = in_valid_i && in_ready_q;
    assign pop         = (state_q != BUF_EMPTY) && out_ready_i;
    assign in_ready_o  = in_ready_q;
    assign out_valid_o = (state_q != BUF_EMPTY);
    assign out_data_o  = head_q;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (state_q)
            BUF_EMPTY: begin
                if (push) begin
                    head_d  = in_data_i;
                    state_d = BUF_ONE;
                end
            end
            BUF_ONE: begin
                if (push && pop) begin
                    head_d = in_data_i;
                end else if (push) begin
                    tail_d  = in_data_i;
                    state_d = BUF_FULL;
                end else if (pop) begin
                    state_d = BUF_EMPTY;
                end
            end
            BUF_FULL: begin
                if (pop) begin
                    head_d  = tail_q;
                    state_d = BUF_ONE;
                end
            end
            default: state_d = BUF_EMPTY;
        endcase
        // Registered ready looks ahead at the next state, so it never depends on out_ready_i combinationally.
        in_ready_d = (state_d != BUF_FULL);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= BUF_EMPTY;
            head_q     <= '0;
            tail_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            in_ready_q <= in_ready_d;
        end
    end

endmodule

// File: rtl/alu_result_stage.sv
// rtl/alu_result_stage.sv - writeback buffer, status register and branch evaluation; V flag enabled by ALU_RESULT_OVF_EN
module alu_result_stage
    import alu_result_pkg::*;
#(
    parameter int W  = DATA_W,
    parameter int RW = REG_W
) (
    input logic                clk,
    input logic                reset,
    alu_result_stage_if.slave  bus
);

    localparam int EW = W + RW + 1;

    logic [EW-1:0] push_data;
    logic [EW-1:0] head_data;
    logic          buf_in_ready;
    logic          buf_out_valid;
    logic          accept;
    logic [2:0]    status_q, status_d;
    logic [2:0]    new_flags;
    logic          br;

    assign push_data = {bus.alu_out, bus.rd_in, bus.wb_en_in};
    assign accept    = bus.in_valid && buf_in_ready;

    result_skid_buf #(.DW(EW)) u_buf (
        .clk         (clk),
        .reset       (reset),
        .in_valid_i  (bus.in_valid),
        .in_ready_o  (buf_in_ready),
        .in_data_i   (push_data),
        .out_valid_o (buf_out_valid),
        .out_ready_i (bus.out_ready),
        .out_data_o  (head_data)
    );

    assign bus.in_ready  = buf_in_ready;
    assign bus.out_valid = buf_out_valid;
    assign bus.C         = head_data[EW-1 -: W];
    assign bus.rd_out    = head_data[RW:1];
    assign bus.wb_en_out = head_data[0];

`ifdef ALU_RESULT_OVF_EN
    assign new_flags = {bus.alu_ovf, bus.alu_n, bus.alu_z};
`else
    assign new_flags = {1'b0, bus.alu_n, bus.alu_z};
`endif

    // Status follows acceptance order, independent of when the entry is written back.
    always_comb begin
        status_d = status_q;
        if (accept && bus.load_status) begin
            status_d = new_flags;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            status_q <= '0;
        end else begin
            status_q <= status_d;
        end
    end

    assign bus.status = status_q;

    // With V held at 0, LT and LE naturally reduce to N and N|Z.
    always_comb begin
        br = 1'b0;
        case (bus.cond)
            COND_AL: br = 1'b1;
            COND_EQ: br = status_q[ST_Z];
            COND_NE: br = !status_q[ST_Z];
            COND_LT: br = status_q[ST_N] ^ status_q[ST_V];
            COND_LE: br = (status_q[ST_N] ^ status_q[ST_V]) | status_q[ST_Z];
            default: br = 1'b0;
        endcase
    end

    assign bus.br_taken = br;

endmodule

// File: doc/alu_result_stage.md
# alu_result_stage

Writeback stage directly downstream of the 16-bit ALU. Captures the ALU result and flags (`out`, `Z`, `N`, `ovf`) into a two-entry elastic buffer, presents them to the register-file writeback port under a valid/ready handshake, and maintains the architectural status register. It also evaluates branch conditions against that status register.

## Interface
Parameters:
- `W`, 16: datapath width, matching the ALU.
- `RW`, 3: register-index width (8 registers).

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  ALU result valid this cycle.
- `in_ready`  out  1  stage can accept; registered, equals "fewer than 2 entries held".
- `alu_out`  in  W  ALU result.
- `alu_z`, `alu_n`, `alu_ovf`  in  1 each  ALU flags.
- `load_status`  in  1  instruction updates the status register.
- `rd_in`  in  RW  destination register.
- `wb_en_in`  in  1  instruction writes a register. `CMP` uses 0.
- `out_valid`  out  1  head entry valid.
- `out_ready`  in  1  register file consumes head.
- `C`  out  W  head result.
- `rd_out`  out  RW  head destination.
- `wb_en_out`  out  1  head write enable.
- `status`  out  3  `{V,N,Z}` architectural flags.
- `cond`  in  3  branch condition code.
- `br_taken`  out  1  condition evaluated on `status`.

## Operation
- Accept: at a rising edge where `in_valid && in_ready`, push `{alu_out, rd_in, wb_en_in}` into the buffer tail.
- Status update: on the same accept edge, if `load_status` is high, `status <= {alu_ovf, alu_n, alu_z}`. Status updates in acceptance order and does not wait for writeback.
- Pop: at a rising edge where `out_valid && out_ready`, drop the head. The second entry, if any, becomes head.
- Buffer states: EMPTY (0 entries), ONE (1), FULL (2).
  - EMPTY→ONE on push.
  - ONE→ONE on push and pop together.
  - ONE→FULL on push without pop.
  - ONE→EMPTY on pop without push.
  - FULL→ONE on pop. No push is possible in FULL because `in_ready` is 0.
- `in_valid` without `in_ready`: ignored. Nothing is stored and status is unchanged. The upstream must hold.
- `out_valid` stays high and head contents stay stable until popped.
- Branch conditions (`cond`):
  - 000: always.
  - 001: EQ, `Z`.
  - 010: NE, `!Z`.
  - 011: LT, `N^V`.
  - 100: LE, `(N^V)|Z`.
  - 101–111: never.
- `br_taken` is combinational from `status` and `cond`.
- Width rules: no arithmetic on data; `C` is passed through unchanged. Entry count is 2 bits and saturates logically at 2.

## Timing
- Latency: a result accepted at edge k is visible on `C`/`out_valid` after edge k when the buffer was EMPTY. Otherwise it appears after the older entry pops.
- Throughput: one result per cycle in steady state with `out_ready` held high.
- `in_ready` is registered. It has no combinational path from `out_ready`, so a pop at edge k reopens `in_ready` after edge k.
- Status written at edge k is seen by `br_taken` after edge k. A compare and a dependent branch need at least one cycle between them.
- Reset, including mid-operation, flushes the buffer:
  - `out_valid`=0, `C`=0, `rd_out`=0, `wb_en_out`=0.
  - `status`=000.
  - `in_ready`=1 after the reset edge.
  - Inputs presented during the reset cycle are discarded.

## Configuration
- `ALU_RESULT_OVF_EN` defined:
  - V is stored from `alu_ovf`.
  - LT/LE use `N^V` as above.
- `ALU_RESULT_OVF_EN` undefined:
  - `status[2]` is constant 0.
  - `alu_ovf` is ignored.
  - LT reduces to `N`; LE reduces to `N|Z`.

## Structure
- Shared package `alu_result_pkg`:
  - condition-code constants `COND_AL`, `COND_EQ`, `COND_NE`, `COND_LT`, `COND_LE`;
  - status bit indices `ST_Z`, `ST_N`, `ST_V`;
  - the entry struct `{C, rd, wb_en}`.
- One sub-module: `result_skid_buf`, the generic two-entry valid/ready buffer parameterised on entry width.
- Status register and branch evaluation stay in the top module.

## Test plan
- Single pass: push 0x0005 to rd=3, wb_en=1, load_status=1 with `out_ready`=1.
  - Next cycle: `out_valid`=1, `C`=0x0005, `rd_out`=3, `status`=000.
  - Popped on the following edge.
- Backpressure: `out_ready`=0, push 0x1111 then 0x2222.
  - `in_ready` drops to 0, and a third push of 0x3333 is not stored.
  - Raising `out_ready` drains 0x1111 then 0x2222 in order.
- Flags and branch: accept `alu_out`=0x8000, N=1, Z=0, ovf=1 with load_status=1.
  - With the macro defined: `status`=110, LT not taken, LE not taken.
  - Without the macro: `status`=010, LT taken.
- Status gating: accept 0x0000 with Z=1, load_status=0.
  - `status` is unchanged.
  - With `cond`=000, `br_taken`=1; with `cond`=111, `br_taken`=0.
- Simultaneous push/pop in ONE: a continuous stream 0x0001..0x0004 with `out_ready`=1.
  - One output per cycle, `in_ready` stays 1.
- Reset mid-operation: assert `reset` with 2 entries held and `status`=111.
  - After the edge: `out_valid`=0, `C`=0, `status`=000, `in_ready`=1.
